dcache_fill_ctrl: RTL and testbench

DCACHE_FILL_CTRL -- requirements
Module: dcache_fill_ctrl

---
 rtl/dcache_fill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dcache_fill_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_fill_ctrl.sv
// D-cache miss fill controller: invalidates the line, fetches two quadwords, arbitrates the cache write port with stores.
// Optional build macro DC_FILL_CRITICAL_WORD_FIRST_EN: critical quadword first with early fill_done.
module dcache_fill_ctrl #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miss_e1,
    input  logic [31:0] miss_addr_e1,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [63:0] st_data,
    input  logic [7:0]  st_be,
    output logic        st_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        write_xx,
    output logic [31:0] write_addr_xx,
    output logic [63:0] write_data_xx,
    output logic [7:0]  write_be_xx,
    output logic        inv_en_e1,
    output logic [5:0]  inv_index_e1,
    output logic        busy,
    output logic        fill_done,
    output logic [63:0] fill_data,
    output logic        fill_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1023) ? $clog2(TIMEOUT + 1) : 10;

    typedef enum logic [2:0] {IDLE, INV, REQ, BEAT0, BEAT1, DONE} state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      fill_data_q, fill_data_d;
    logic             abort_q, abort_d;
    logic             beat_qw;
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
    logic             early_q, early_d;
`endif

`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
    assign beat_qw = (state_q == BEAT1) ^ addr_q[3];
`else
    assign beat_qw = (state_q == BEAT1);
`endif

    assign mem_addr     = {addr_q[31:4], 4'b0000};
    assign inv_index_e1 = addr_q[9:4];
    assign fill_data    = fill_data_q;
    assign busy         = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            fill_data_q <= '0;
            abort_q     <= 1'b0;
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
            early_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            fill_data_q <= fill_data_d;
            abort_q     <= abort_d;
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
            early_q     <= early_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        fill_data_d   = fill_data_q;
        abort_d       = abort_q;
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
        early_d       = 1'b0;
`endif
        st_ack        = 1'b0;
        mem_req       = 1'b0;
        write_xx      = 1'b0;
        write_addr_xx = {addr_q[31:4], beat_qw, 3'b000};
        write_data_xx = mem_rdata;
        write_be_xx   = 8'hFF;
        inv_en_e1     = 1'b0;
        fill_done     = 1'b0;
        fill_err      = 1'b0;

        case (state_q)
            IDLE: begin
                // Stores own the write port only while no fill is in flight.
                st_ack        = st_req;
                write_xx      = st_req;
                write_addr_xx = st_addr;
                write_data_xx = st_data;
                write_be_xx   = st_be;
                if (miss_e1) begin
                    addr_d  = miss_addr_e1;
                    abort_d = 1'b0;
                    state_d = INV;
                end
            end
            INV: begin
                inv_en_e1 = 1'b1;
                if (abort_q) begin
                    fill_err = 1'b1;
                    abort_d  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d  = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = BEAT0;
                end
            end
            BEAT0, BEAT1: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    write_xx = 1'b1;
                    if (beat_qw == addr_q[3]) fill_data_d = mem_rdata;
                    state_d = (state_q == BEAT0) ? BEAT1 : DONE;
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
                    early_d = (state_q == BEAT0);
`endif
                end
                // Timeout loses only to the final beat landing in the same cycle.
                if (cnt_q == CNT_W'(TIMEOUT - 1) && !(mem_rvalid && state_q == BEAT1)) begin
                    abort_d = 1'b1;
                    state_d = INV;
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
                    early_d = 1'b0;
`endif
                end
            end
            DONE: begin
`ifndef DC_FILL_CRITICAL_WORD_FIRST_EN
                fill_done = 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
        fill_done = early_q;
`endif
    end

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Self-checking bench for dcache_fill_ctrl: event-queue model of expected writes/invalidates/completions plus directed literals.
module tb_dcache_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_e1;
    logic [31:0] miss_addr_e1;
    logic        st_req;
    logic [31:0] st_addr;
    logic [63:0] st_data;
    logic [7:0]  st_be;
    logic        st_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        write_xx;
    logic [31:0] write_addr_xx;
    logic [63:0] write_data_xx;
    logic [7:0]  write_be_xx;
    logic        inv_en_e1;
    logic [5:0]  inv_index_e1;
    logic        busy;
    logic        fill_done;
    logic [63:0] fill_data;
    logic        fill_err;

    dcache_fill_ctrl #(.TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset),
        .miss_e1(miss_e1), .miss_addr_e1(miss_addr_e1),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_ack(st_ack),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_xx(write_xx), .write_addr_xx(write_addr_xx),
        .write_data_xx(write_data_xx), .write_be_xx(write_be_xx),
        .inv_en_e1(inv_en_e1), .inv_index_e1(inv_index_e1),
        .busy(busy), .fill_done(fill_done), .fill_data(fill_data), .fill_err(fill_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [63:0] d; logic [7:0] be; } wr_t;

    int n_chk = 0;
    int n_fail = 0;

    // Model: ordered expectations of externally visible events.
    wr_t         exp_wr[$];
    logic [5:0]  exp_inv[$];
    logic [63:0] exp_done[$];
    int          exp_err = 0;
    logic [31:0] exp_maddr = '0;
    logic [63:0] mem_line [2];
    logic [31:0] cur_addr;

    // Observations used by directed literal checks.
    int          cyc_n = 0;
    int          done_cnt = 0, err_cnt = 0, ack_cnt = 0;
    int          done_cyc = 0, err_cyc = 0, gnt_cyc = 0;
    int          wr_cyc[$];
    logic [31:0] wr_addr_log[$];
    logic [5:0]  last_inv = '0;
    logic [31:0] last_maddr = '0;
    wr_t         e_wr;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing or bound expired", name);
    endfunction

    function automatic logic beat_qw(input int k, input logic crit);
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
        return (k == 0) ? crit : !crit;
`else
        return (k == 1);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
        exp_wr.push_back('{a, d, be});
    endtask

    task automatic expect_fill(input logic [31:0] a, input bit aborts);
        logic [31:0] line;
        logic        qw;
        line      = {a[31:4], 4'b0000};
        exp_maddr = line;
        exp_inv.push_back(a[9:4]);
        if (aborts) begin
            exp_inv.push_back(a[9:4]);
            exp_err++;
        end else begin
            for (int k = 0; k < 2; k++) begin
                qw = beat_qw(k, a[3]);
                exp_wr.push_back('{line + (qw ? 32'd8 : 32'd0), mem_line[qw], 8'hFF});
            end
            exp_done.push_back(mem_line[a[3]]);
        end
    endtask

    task automatic start_miss(input logic [31:0] a);
        cur_addr     = a;
        miss_e1      = 1'b1;
        miss_addr_e1 = a;
        step();
        miss_e1      = 1'b0;
        miss_addr_e1 = '0;
    endtask

    task automatic wait_mem_req();
        int w = 0;
        while (!mem_req && w < 20) begin step(); w++; end
        if (!mem_req) fail_now("mem_req_wait");
    endtask

    task automatic serve_fill(input int gnt_delay, input bit stray, input bit hold_store);
        int w = 0;
        wait_mem_req();
        for (int i = 0; i < gnt_delay; i++) begin
            mem_rvalid = stray;
            mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        gnt_cyc    = cyc_n + 1;
        step();
        mem_gnt    = 1'b0;
        if (hold_store) begin
            st_req = 1'b1;
            for (int i = 0; i < 3; i++) step();
        end
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_line[beat_qw(k, cur_addr[3])];
            step();
        end
        mem_rvalid = 1'b0;
        while (busy && w < 20) begin step(); w++; end
        if (busy) fail_now("busy_wait");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   mem_req,   0);
        chk({tag, "_write_xx"},  write_xx,  0);
        chk({tag, "_st_ack"},    st_ack,    0);
        chk({tag, "_inv_en"},    inv_en_e1, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_fill_done"}, fill_done, 0);
        chk({tag, "_fill_err"},  fill_err,  0);
        chk({tag, "_fill_data"}, fill_data, 0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
    endtask

    // Per-cycle compare against the event model.
    always @(negedge clk) begin
        cyc_n++;
        if (!reset) begin
            chk("st_ack_rule", st_ack, st_req && !busy);
            chk("write_in_inv_or_req", write_xx && (inv_en_e1 || mem_req), 0);
            if (st_ack) ack_cnt++;
            if (write_xx) begin
                wr_addr_log.push_back(write_addr_xx);
                wr_cyc.push_back(cyc_n);
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    e_wr = exp_wr.pop_front();
                    chk("write_addr", write_addr_xx, e_wr.a);
                    chk("write_data", write_data_xx, e_wr.d);
                    chk("write_be",   write_be_xx,   e_wr.be);
                end
            end
            if (inv_en_e1) begin
                last_inv = inv_index_e1;
                if (exp_inv.size() == 0) fail_now("unexpected_inv");
                else chk("inv_index", inv_index_e1, exp_inv.pop_front());
            end
            if (mem_req) begin
                last_maddr = mem_addr;
                chk("mem_addr", mem_addr, exp_maddr);
            end
            if (fill_done) begin
                done_cnt++;
                done_cyc = cyc_n;
                if (exp_done.size() == 0) fail_now("unexpected_fill_done");
                else chk("fill_data", fill_data, exp_done.pop_front());
            end
            if (fill_err) begin
                err_cnt++;
                err_cyc = cyc_n;
                if (exp_err == 0) fail_now("unexpected_fill_err");
                else exp_err--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lat;
        reset = 1'b1; miss_e1 = 1'b0; miss_addr_e1 = '0;
        st_req = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) step();
        check_reset_outputs("rst0");
        reset = 1'b0;
        step();

        // Miss at 0x1238 with a concurrent IDLE store; grant two cycles late.
        mem_line[0] = 64'hD0D0_0000_0000_00D0;
        mem_line[1] = 64'hD1D1_0000_0000_00D1;
        expect_store(32'h40, 64'h0000_0000_CAFE_F00D, 8'h0F);
        expect_fill(32'h0000_1238, 1'b0);
        ack_cnt = 0; done_cnt = 0;
        st_req = 1'b1; st_addr = 32'h40; st_data = 64'h0000_0000_CAFE_F00D; st_be = 8'h0F;
        start_miss(32'h0000_1238);
        st_req = 1'b0;
        chk("t1_store_acked", ack_cnt, 1);
        serve_fill(2, 1'b0, 1'b0);
        chk("t1_inv_index", last_inv, 6'h23);
        chk("t1_mem_addr", last_maddr, 32'h0000_1230);
        chk("t1_store_addr", wr_addr_log[0], 32'h40);
`ifdef DC_FILL_CRITICAL_WORD_FIRST_EN
        chk("t1_first_fill_addr", wr_addr_log[1], 32'h0000_1238);
        chk("t1_second_fill_addr", wr_addr_log[2], 32'h0000_1230);
        chk("t1_done_after_first", done_cyc, wr_cyc[1] + 1);
`else
        chk("t1_first_fill_addr", wr_addr_log[1], 32'h0000_1230);
        chk("t1_second_fill_addr", wr_addr_log[2], 32'h0000_1238);
        chk("t1_done_after_second", done_cyc, wr_cyc[2] + 1);
`endif
        chk("t1_done_count", done_cnt, 1);
        chk("t1_fill_data", fill_data, 64'hD1D1_0000_0000_00D1);

        // Store held across a fill (with a stray rvalid before grant): acked once after IDLE.
        mem_line[0] = 64'h2000_0000_0000_AAAA;
        mem_line[1] = 64'h2008_0000_0000_BBBB;
        expect_fill(32'h0000_2000, 1'b0);
        expect_store(32'h80, 64'h1111_2222_3333_4444, 8'hFF);
        ack_cnt = 0;
        st_addr = 32'h80; st_data = 64'h1111_2222_3333_4444; st_be = 8'hFF;
        start_miss(32'h0000_2000);
        serve_fill(1, 1'b1, 1'b1);
        step();
        st_req = 1'b0;
        step();
        chk("t2_ack_once", ack_cnt, 1);
        chk("t2_fill_data", fill_data, 64'h2000_0000_0000_AAAA);

        // Stray rvalid in IDLE must not write.
        w = wr_addr_log.size();
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step(); step();
        mem_rvalid = 1'b0;
        step();
        chk("t3_no_stray_write", wr_addr_log.size(), w);

        // Grant then silence: timeout abort.
        expect_fill(32'h0000_0A50, 1'b1);
        done_cnt = 0; err_cnt = 0;
        start_miss(32'h0000_0A50);
        wait_mem_req();
        mem_gnt = 1'b1;
        gnt_cyc = cyc_n + 1;
        step();
        mem_gnt = 1'b0;
        w = 0;
        while (!fill_err && w < 1200) begin step(); w++; end
        if (!fill_err) fail_now("t4_fill_err_wait");
        else begin
            chk("t4_inv_with_err", inv_en_e1, 1);
            chk("t4_inv_index", inv_index_e1, 6'h25);
            lat = cyc_n + 1 - gnt_cyc;
            chk("t4_timeout_latency_range", (lat >= 1023 && lat <= 1025), 1);
            step();
            chk("t4_busy_low_after", busy, 0);
        end
        chk("t4_err_count", err_cnt, 1);
        chk("t4_no_fill_done", done_cnt, 0);

        // Reset in BEAT1, then rvalid: abandoned, nothing written.
        mem_line[0] = 64'h5555_0000_0000_0050;
        mem_line[1] = 64'h5555_0000_0000_0051;
        expect_fill(32'h0000_1238, 1'b0);
        start_miss(32'h0000_1238);
        wait_mem_req();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = mem_line[beat_qw(0, 1'b1)];
        step();
        mem_rvalid = 1'b0;
        reset = 1'b1;
        exp_wr.delete(); exp_inv.delete(); exp_done.delete(); exp_err = 0;
        step();
        mem_rvalid = 1'b1; mem_rdata = mem_line[beat_qw(1, 1'b1)];
        check_reset_outputs("rst1");
        step();
        reset = 1'b0;
        w = wr_addr_log.size();
        step(); step();
        mem_rvalid = 1'b0;
        step();
        chk("t5_no_write_after_reset", wr_addr_log.size(), w);
        chk("t5_busy_idle", busy, 0);

        chk("end_exp_writes_empty", exp_wr.size(), 0);
        chk("end_exp_inv_empty", exp_inv.size(), 0);
        chk("end_exp_done_empty", exp_done.size(), 0);
        chk("end_exp_err_zero", exp_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
